// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded bundle at the end of ID, with stall (hold) and flush (bubble).
// Optional feature: define IDEX_PERF_CNT_EN to add saturating bubble/stall counters.
module id_ex_stage_reg #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int ALU_OP_W   = 4,
  parameter int WB_SEL_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rdata_a,
  input  logic [DATA_W-1:0]     id_rdata_b,
  input  logic [DATA_W-1:0]     id_im,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  id_alu_src_b,
  input  logic                  id_mem_rd,
  input  logic                  id_mem_wr,
  input  logic                  id_reg_we,
  input  logic [WB_SEL_W-1:0]   id_wb_sel,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rdata_a,
  output logic [DATA_W-1:0]     ex_rdata_b,
  output logic [DATA_W-1:0]     ex_im,
  output logic [REG_ADDR_W-1:0] ex_rs_addr,
  output logic [REG_ADDR_W-1:0] ex_rt_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_alu_src_b,
  output logic                  ex_mem_rd,
  output logic                  ex_mem_wr,
  output logic                  ex_reg_we,
  output logic [WB_SEL_W-1:0]   ex_wb_sel
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [15:0]           ex_bubble_cnt,
  output logic [15:0]           ex_stall_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rdata_a;
    logic [DATA_W-1:0]     rdata_b;
    logic [DATA_W-1:0]     im;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  alu_src_b;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  reg_we;
    logic [WB_SEL_W-1:0]   wb_sel;
  } bundle_t;

  bundle_t id_next;
  bundle_t ex_q;

  // NOTE: every field gets its value before any conditional override, so no latch can be inferred.
  always_comb begin
    id_next = '{valid:     id_valid,
                pc:        id_pc,
                rdata_a:   id_rdata_a,
                rdata_b:   id_rdata_b,
                im:        id_im,
                rs_addr:   id_rs_addr,
                rt_addr:   id_rt_addr,
                rd_addr:   id_rd_addr,
                alu_op:    id_alu_op,
                alu_src_b: id_alu_src_b,
                mem_rd:    id_mem_rd,
                mem_wr:    id_mem_wr,
                reg_we:    id_reg_we,
                wb_sel:    id_wb_sel};
    // A slot without a real instruction must never write architectural state.
    if (!id_valid) begin
      id_next.mem_rd = 1'b0;
      id_next.mem_wr = 1'b0;
      id_next.reg_we = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= id_next;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rdata_a   = ex_q.rdata_a;
  assign ex_rdata_b   = ex_q.rdata_b;
  assign ex_im        = ex_q.im;
  assign ex_rs_addr   = ex_q.rs_addr;
  assign ex_rt_addr   = ex_q.rt_addr;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_alu_src_b = ex_q.alu_src_b;
  assign ex_mem_rd    = ex_q.mem_rd;
  assign ex_mem_wr    = ex_q.mem_wr;
  assign ex_reg_we    = ex_q.reg_we;
  assign ex_wb_sel    = ex_q.wb_sel;

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] bubble_cnt_q;
  logic [15:0] stall_cnt_q;

  // Counters saturate rather than wrap so a long run never reports a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if (flush) begin
      if (bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end else if (stall) begin
      if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign ex_bubble_cnt = bubble_cnt_q;
  assign ex_stall_cnt  = stall_cnt_q;
`endif

endmodule
